// File: rtl/masked_and_sched_if.sv
// Requester, gate and response signals of the masked AND scheduler.
// The scheduler takes the slave view; requesters plus gate take the master view.
interface masked_and_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a0;
    logic [NREQ*W-1:0] req_a1;
    logic [NREQ*W-1:0] req_b0;
    logic [NREQ*W-1:0] req_b1;
    logic [W-1:0]      g_a0;
    logic [W-1:0]      g_a1;
    logic [W-1:0]      g_b0;
    logic [W-1:0]      g_b1;
    logic [W-1:0]      g_q0;
    logic [W-1:0]      g_q1;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_q0;
    logic [W-1:0]      rsp_q1;
    logic              busy;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, g_q0, g_q1,
        input  req_ready, g_a0, g_a1, g_b0, g_b1, rsp_valid, rsp_q0, rsp_q1, busy
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, g_q0, g_q1,
        output req_ready, g_a0, g_a1, g_b0, g_b1, rsp_valid, rsp_q0, rsp_q1, busy
    );
endinterface

// File: rtl/masked_and_sched.sv
// Round-robin scheduler sharing one 2-share masked AND gate among NREQ requesters.
// Idle gate inputs and unstrobed result shares are always driven to zero.
module masked_and_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 2,
    parameter int GAP  = 1
) (
    input logic               clk,
    input logic               rst,
    masked_and_sched_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_QUIET = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [2:0]      cnt_r;
    logic [2:0]      cnt_n;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_n;
    logic [PW-1:0]   grant_s;
    logic [PW:0]     sum_s;
    logic [PW:0]     idx_s;
    logic            found_s;
    logic            hit_s;
    logic            accept_s;
    logic [NREQ-1:0] ready_s;
    logic [NREQ-1:0] rsp_onehot_s;
    logic [LAT:0]    tag_v_r;
    logic [PW-1:0]   tag_id_r [LAT+1];

    // Rotating priority search: first valid requester starting at ptr wins.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s   = {1'b0, ptr_r} + (PW+1)'(k);
            idx_s   = (sum_s >= (PW+1)'(NREQ)) ? (sum_s - (PW+1)'(NREQ)) : sum_s;
            hit_s   = bus.req_valid[idx_s[PW-1:0]];
            grant_s = (!found_s && hit_s) ? idx_s[PW-1:0] : grant_s;
            found_s = found_s | hit_s;
        end
    end

    // Ready is only ever offered in IDLE, to the single granted requester.
    always_comb begin
        ready_s = '0;
        if (state_r == ST_IDLE && found_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s      = |(ready_s & bus.req_valid);
    assign bus.req_ready = ready_s;
    assign bus.busy      = (state_r != ST_IDLE) | (|tag_v_r) | (|bus.rsp_valid);

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ptr_r   <= ptr_n;
        end
    end

    // Next state: an issue opens GAP quiet cycles and advances the pointer past the grantee.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        ptr_n   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ptr_n = (grant_s == PW'(NREQ - 1)) ? '0 : (grant_s + PW'(1));
                    if (GAP > 0) begin
                        state_n = ST_QUIET;
                        cnt_n   = 3'(GAP);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_QUIET: begin
                cnt_n = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_QUIET;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 3'd0;
            end
        endcase
    end

    // Owner one-hot for the tag leaving the last pipeline stage.
    always_comb begin
        rsp_onehot_s = '0;
        if (tag_v_r[LAT]) begin
            rsp_onehot_s[tag_id_r[LAT]] = 1'b1;
        end else begin
            rsp_onehot_s = '0;
        end
    end

    // Gate operand registers, ownership tags and result capture; shares stay separate words.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.g_a0      <= '0;
            bus.g_a1      <= '0;
            bus.g_b0      <= '0;
            bus.g_b1      <= '0;
            tag_v_r       <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id_r[s] <= '0;
            end
            bus.rsp_valid <= '0;
            bus.rsp_q0    <= '0;
            bus.rsp_q1    <= '0;
        end else begin
            if (accept_s) begin
                bus.g_a0 <= bus.req_a0[int'(grant_s)*W +: W];
                bus.g_a1 <= bus.req_a1[int'(grant_s)*W +: W];
                bus.g_b0 <= bus.req_b0[int'(grant_s)*W +: W];
                bus.g_b1 <= bus.req_b1[int'(grant_s)*W +: W];
            end else begin
                bus.g_a0 <= '0;
                bus.g_a1 <= '0;
                bus.g_b0 <= '0;
                bus.g_b1 <= '0;
            end
            tag_v_r     <= {tag_v_r[LAT-1:0], accept_s};
            tag_id_r[0] <= grant_s;
            for (int s = 1; s <= LAT; s++) begin
                tag_id_r[s] <= tag_id_r[s-1];
            end
            bus.rsp_valid <= rsp_onehot_s;
            bus.rsp_q0    <= tag_v_r[LAT] ? bus.g_q0 : '0;
            bus.rsp_q1    <= tag_v_r[LAT] ? bus.g_q1 : '0;
        end
    end
endmodule
